// File: rtl/vec_mem_sequencer.sv
// Burst sequencer that moves one 256-bit vector between the vector datapath and the 16-bit memory port.
// Optional VSEQ_ZERO_FILL_EN: clear ld_vector when a load is accepted so lanes above last_idx read 0.
module vec_mem_sequencer #(
    parameter int WORD_W = 16,
    parameter int LANES  = 16
) (
    input  logic                      Clk1,
    input  logic                      Reset,
    input  logic                      start,
    input  logic                      is_store,
    input  logic [15:0]               base_addr,
    input  logic [$clog2(LANES)-1:0]  last_idx,
    input  logic [WORD_W*LANES-1:0]   st_vector,
    input  logic [WORD_W-1:0]         DataIn,
    output logic [15:0]               Addr,
    output logic                      RD,
    output logic                      WR,
    output logic [WORD_W-1:0]         dataOut,
    output logic [WORD_W*LANES-1:0]   ld_vector,
    output logic                      busy,
    output logic                      done
);
    localparam int IDX_W = $clog2(LANES);
    localparam int AW    = 16;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               j_q, j_d;
    logic [IDX_W-1:0]               j_inc;
    logic                           store_q, store_d;
    logic [AW-1:0]                  base_q, base_d;
    logic [IDX_W-1:0]               last_q, last_d;
    logic [LANES-1:0][WORD_W-1:0]   st_vec_q, st_vec_d;
    logic [LANES-1:0][WORD_W-1:0]   ld_vec_q, ld_vec_d;
    logic [AW-1:0]                  addr_q, addr_d;
    logic                           rd_q, rd_d;
    logic                           wr_q, wr_d;
    logic [WORD_W-1:0]              dout_q, dout_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           pend_q, pend_d;
    logic [IDX_W-1:0]               pend_idx_q, pend_idx_d;

    assign j_inc = j_q + {{(IDX_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        store_d    = store_q;
        base_d     = base_q;
        last_d     = last_q;
        st_vec_d   = st_vec_q;
        ld_vec_d   = ld_vec_q;
        addr_d     = '0;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        dout_d     = '0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        // Read data returns one cycle after RD, so remember which lane is in flight.
        pend_d     = rd_q;
        pend_idx_d = j_q;

        if (pend_q) ld_vec_d[pend_idx_q] = DataIn;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d  = S_ISSUE;
                    j_d      = '0;
                    store_d  = is_store;
                    base_d   = base_addr;
                    last_d   = last_idx;
                    st_vec_d = st_vector;
                    busy_d   = 1'b1;
                    addr_d   = base_addr;
                    if (is_store) begin
                        wr_d   = 1'b1;
                        dout_d = st_vector[WORD_W-1:0];
                    end else begin
                        rd_d   = 1'b1;
`ifdef VSEQ_ZERO_FILL_EN
                        ld_vec_d = '0;
`else
                        ld_vec_d = ld_vec_q;
`endif
                    end
                end
            end
            S_ISSUE: begin
                if (j_q == last_q) begin
                    if (store_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                        busy_d  = 1'b1;
                    end
                end else begin
                    j_d    = j_inc;
                    busy_d = 1'b1;
                    // 16-bit add wraps 0xFFFF -> 0x0000 naturally.
                    addr_d = base_q + {{(AW-IDX_W){1'b0}}, j_inc};
                    if (store_q) begin
                        wr_d   = 1'b1;
                        dout_d = st_vec_q[j_inc];
                    end else begin
                        rd_d   = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            j_q        <= '0;
            store_q    <= 1'b0;
            base_q     <= '0;
            last_q     <= '0;
            st_vec_q   <= '0;
            ld_vec_q   <= '0;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            dout_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            store_q    <= store_d;
            base_q     <= base_d;
            last_q     <= last_d;
            st_vec_q   <= st_vec_d;
            ld_vec_q   <= ld_vec_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
        end
    end

    assign Addr      = addr_q;
    assign RD        = rd_q;
    assign WR        = wr_q;
    assign dataOut   = dout_q;
    assign ld_vector = ld_vec_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/vec_mem_sequencer.md
# vec_mem_sequencer

Burst sequencer that moves one 256-bit vector register between the vector datapath and the single 16-bit memory port of the CVP14 core. On a `start` command it issues a run of up to 16 consecutive word reads (VLD) or writes (VST) starting at a base address. For loads it assembles the returned words into a vector; for stores it serializes a vector onto `dataOut`. The core FSM uses it in place of its inline Load/Store states and waits for `done`.

## Interface
- `WORD_W`, default 16: memory word width; fixed to 16 in this design.
- `LANES`, default 16: words per vector; the vector width is `WORD_W*LANES` = 256.

- `Clk1`, input, 1: clock; all state changes on its rising edge.
- `Reset`, input, 1: reset is synchronous and active-high.
- `start`, input, 1: command strobe; sampled only while `busy`=0.
- `is_store`, input, 1: 1 = VST (write burst), 0 = VLD (read burst); latched with `start`.
- `base_addr`, input, 16: address of lane 0; latched with `start`.
- `last_idx`, input, 4: index of the final lane; the burst length is N = `last_idx`+1; latched with `start`.
- `st_vector`, input, 256: store data, lane i = bits [16i+15:16i]; latched with `start`.
- `DataIn`, input, 16: memory read data, valid the cycle after `RD`.
- `Addr`, output, 16: memory address (registered).
- `RD`, output, 1: read strobe (registered).
- `WR`, output, 1: write strobe (registered).
- `dataOut`, output, 16: write data, valid while `WR`=1 (registered).
- `ld_vector`, output, 256: assembled load vector; stable from `done` until the next load starts.
- `busy`, output, 1: high in ISSUE and DRAIN.
- `done`, output, 1: single-cycle completion pulse.

## Operation
- States:
  - IDLE: `busy`=0. `start`=1 latches all operands, clears the lane index j to 0, and moves to ISSUE.
  - ISSUE: `busy`=1; drives one transfer per cycle for j = 0..`last_idx`. After j=`last_idx`, a load goes to DRAIN and a store goes to DONE.
  - DRAIN (load only): `RD`=0; captures the final lane, then goes to DONE.
  - DONE: `done`=1, `busy`=0. Behaves as IDLE otherwise: a `start` seen in DONE is accepted and the FSM goes directly to ISSUE, so back-to-back bursts have no gap.
- ISSUE cycle j drives `Addr` = `base_addr` + j, computed modulo 2^16 so 0xFFFF is followed by 0x0000.
  - Load: `RD`=1, `WR`=0.
  - Store: `WR`=1, `RD`=0, `dataOut` = lane j of the latched `st_vector`.
- Load capture: the `DataIn` present in the cycle after the read of lane j is written into `ld_vector` lane j. Lanes above `last_idx` are handled per Configuration.
- `start` while `busy`=1 is ignored. The latched operands are not disturbed.
- `RD` and `WR` are never both 1 in the same cycle.
- Outside ISSUE: `RD`=`WR`=0, and `Addr` and `dataOut` hold 0.

## Timing
- Reset values: `Addr`=0, `RD`=0, `WR`=0, `dataOut`=0, `ld_vector`=0, `busy`=0, `done`=0; state = IDLE.
- Let the `start` edge be edge 0.
  - ISSUE occupies cycles 1..N.
  - Load: DRAIN is cycle N+1 and `done` is cycle N+2. Load latency is N+2 cycles.
  - Store: `done` is cycle N+1. Store latency is N+1 cycles.
- `last_idx`=0 gives a single-word transfer. `last_idx`=15 gives a full vector.
- `Reset` asserted mid-burst:
  - At the next edge all outputs take their reset values and the burst is abandoned.
  - No further `RD` or `WR` is issued.
  - A `DataIn` that arrives afterwards is not captured.
- `Reset` has priority over a simultaneous `start`.

## Configuration
- `VSEQ_ZERO_FILL_EN`:
  - Defined: on accepting a load, `ld_vector` is cleared to 0 in the first ISSUE cycle, so lanes above `last_idx` read as 0 at `done`.
  - Undefined: lanes above `last_idx` keep their values from the previous load. Only lanes 0..`last_idx` are written.
- The macro does not affect stores.

## Test plan
- Full load: `base_addr`=0x0100, `last_idx`=15, memory word k = 0xA000+k.
  - `RD` is high for 16 consecutive cycles on `Addr` 0x0100..0x010F.
  - `done` pulses at cycle 18.
  - `ld_vector` lane k = 0xA000+k.
- Full store: `st_vector` lane k = 0x5A00+k, `base_addr`=0x2000.
  - `WR` is high for 16 cycles with `dataOut` 0x5A00..0x5A0F on `Addr` 0x2000..0x200F.
  - `done` pulses at cycle 17.
  - `RD` stays 0 throughout.
- Partial load with address wrap: the previous load left all lanes 0xFFFF; then `base_addr`=0xFFFE, `last_idx`=3.
  - `Addr` sequence is 0xFFFE, 0xFFFF, 0x0000, 0x0001.
  - Lanes 4..15 are 0 with `VSEQ_ZERO_FILL_EN` defined, and 0xFFFF without it.
- Back-to-back commands: a store (`last_idx`=1) with a load asserted in its DONE cycle.
  - `RD` rises in the cycle immediately after `done`.
  - A `start` pulsed mid-burst is ignored: exactly 2 writes and no extra transfer.
- Reset mid-load: `Reset` asserted in ISSUE cycle 5 of a 16-word load.
  - `RD`, `busy` and `done` are all 0 from the next cycle, and `ld_vector`=0.
  - A subsequent `start` performs a clean burst from lane 0.
